// File: rtl/request_unit_if.sv
// rtl/request_unit_if.sv - control/memory-side signal bundle for request_unit
interface request_unit_if;
  logic [31:0] imemload;
  logic        ihit;
  logic        dhit;
  logic        dREN;
  logic        dWEN;
  logic        halt;
  logic [31:0] instruction;
  logic        imemREN;
  logic        dmemREN;
  logic        dmemWEN;
  logic        pc_en;
  logic        halted;
  logic [31:0] retired;
  logic        timeout_err;

  modport slave (
    input  imemload, ihit, dhit, dREN, dWEN, halt,
    output instruction, imemREN, dmemREN, dmemWEN, pc_en, halted, retired, timeout_err
  );

  modport master (
    output imemload, ihit, dhit, dREN, dWEN, halt,
    input  instruction, imemREN, dmemREN, dmemWEN, pc_en, halted, retired, timeout_err
  );
endinterface

// File: rtl/request_unit.sv
// rtl/request_unit.sv - fetch/data request sequencer; optional hit watchdog under REQ_TIMEOUT_EN
module request_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RST,
  request_unit_if.slave ruif
);

  typedef enum logic [1:0] {FETCH, EXEC, DATA, HALT} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instruction;
  logic [31:0] r_retired;
  logic        r_store;
  logic        w_pc_en;
  logic        w_is_mem;
  logic        w_trip;

  assign w_is_mem = ruif.dREN | ruif.dWEN;

`ifdef REQ_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_inc;
  logic       r_timeout_err;
  logic       w_waiting;

  // Counter is zero whenever not stalled, so it is clear on every entry to FETCH or DATA.
  assign w_waiting  = ((r_state == FETCH) && !ruif.ihit) || ((r_state == DATA) && !ruif.dhit);
  assign w_wait_inc = r_wait_cnt + 8'd1;
  assign w_trip     = w_waiting && (w_wait_inc == TIMEOUT[7:0]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wait_cnt    <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wait_cnt <= w_waiting ? w_wait_inc : 8'd0;
      if (w_trip) r_timeout_err <= 1'b1;
    end
  end

  assign ruif.timeout_err = r_timeout_err;
`else
  assign w_trip           = 1'b0;
  assign ruif.timeout_err = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_pc_en = 1'b0;
    case (r_state)
      FETCH: begin
        if (ruif.ihit)  w_next = EXEC;
        else if (w_trip) w_next = HALT;
      end
      EXEC: begin
        if (ruif.halt) begin
          w_next = HALT;
        end else if (w_is_mem) begin
          w_next = DATA;
        end else begin
          w_pc_en = 1'b1;
          w_next  = FETCH;
        end
      end
      DATA: begin
        if (ruif.dhit) begin
          w_pc_en = 1'b1;
          w_next  = FETCH;
        end else if (w_trip) begin
          w_next = HALT;
        end
      end
      HALT:    w_next = HALT;
      default: w_next = FETCH;
    endcase
    if (RST) w_pc_en = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= FETCH;
      r_instruction <= 32'd0;
      r_retired     <= 32'd0;
      r_store       <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == FETCH) && ruif.ihit) r_instruction <= ruif.imemload;
      // Store wins when the decode flags both directions.
      if ((r_state == EXEC) && !ruif.halt && w_is_mem) r_store <= ruif.dWEN;
      if (w_pc_en) r_retired <= r_retired + 32'd1;
    end
  end

  assign ruif.imemREN     = !RST && (r_state == FETCH);
  assign ruif.dmemREN     = !RST && (r_state == DATA) && !r_store;
  assign ruif.dmemWEN     = !RST && (r_state == DATA) && r_store;
  assign ruif.pc_en       = w_pc_en;
  assign ruif.halted      = (r_state == HALT);
  assign ruif.instruction = r_instruction;
  assign ruif.retired     = r_retired;

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - self-checking bench for request_unit (vector table, random transactions, corner sequences)
module tb_request_unit;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;

  request_unit_if ruif ();

`ifdef REQ_TIMEOUT_EN
  request_unit #(.TIMEOUT(4)) dut (.CLK(CLK), .RST(RST), .ruif(ruif.slave));
`else
  request_unit dut (.CLK(CLK), .RST(RST), .ruif(ruif.slave));
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, ihit, dhit, dren, dwen, halt;
    logic [31:0] imem;
    logic        e_imem, e_dren, e_dwen, e_pc, e_halted;
    logic [31:0] e_ret, e_instr;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ihit, input logic dhit, input logic dren,
                       input logic dwen, input logic halt, input logic [31:0] imem);
    RST           = rst;
    ruif.ihit     = ihit;
    ruif.dhit     = dhit;
    ruif.dREN     = dren;
    ruif.dWEN     = dwen;
    ruif.halt     = halt;
    ruif.imemload = imem;
    #2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_outs(input string tag, input logic e_imem, input logic e_dren, input logic e_dwen,
                             input logic e_pc, input logic e_halted, input logic [31:0] e_ret);
    check({tag, " imemREN"}, ruif.imemREN, e_imem);
    check({tag, " dmemREN"}, ruif.dmemREN, e_dren);
    check({tag, " dmemWEN"}, ruif.dmemWEN, e_dwen);
    check({tag, " pc_en"},   ruif.pc_en,   e_pc);
    check({tag, " halted"},  ruif.halted,  e_halted);
    check({tag, " retired"}, ruif.retired, e_ret);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("reset imemREN forced", ruif.imemREN, 1'b0);
    check("reset pc_en forced", ruif.pc_en, 1'b0);
    tick();
  endtask

  initial begin
    logic [31:0] model_retired;
    logic [31:0] word;
    int          fw, dw, kind;

    n_checks = 0;
    n_errors = 0;

    //           rst ihit dhit dren dwen halt imem          imem dren dwen pc  hlt ret    instr
    vecs[0]  = '{0, 1, 0, 0, 0, 0, 32'h00221820, 1, 0, 0, 0, 0, 32'd0, 32'h00000000};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 32'h00000000, 0, 0, 0, 1, 0, 32'd0, 32'h00221820};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0, 32'd1, 32'h00221820};
    vecs[3]  = '{0, 1, 0, 0, 0, 0, 32'h8C220004, 1, 0, 0, 0, 0, 32'd1, 32'h00221820};
    vecs[4]  = '{0, 0, 0, 1, 0, 0, 32'h00000000, 0, 0, 0, 0, 0, 32'd1, 32'h8C220004};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 32'h11111111, 0, 1, 0, 0, 0, 32'd1, 32'h8C220004};
    vecs[6]  = '{0, 1, 0, 0, 0, 0, 32'h22222222, 0, 1, 0, 0, 0, 32'd1, 32'h8C220004};
    vecs[7]  = '{0, 1, 0, 0, 0, 0, 32'h33333333, 0, 1, 0, 0, 0, 32'd1, 32'h8C220004};
    vecs[8]  = '{0, 0, 1, 0, 0, 0, 32'h00000000, 0, 1, 0, 1, 0, 32'd1, 32'h8C220004};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 32'hAC220004, 1, 0, 0, 0, 0, 32'd2, 32'h8C220004};
    vecs[10] = '{0, 0, 0, 1, 1, 0, 32'h00000000, 0, 0, 0, 0, 0, 32'd2, 32'hAC220004};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 32'h00000000, 0, 0, 1, 0, 0, 32'd2, 32'hAC220004};
    vecs[12] = '{0, 0, 1, 0, 0, 0, 32'h00000000, 0, 0, 1, 1, 0, 32'd2, 32'hAC220004};
    vecs[13] = '{0, 0, 1, 0, 0, 0, 32'h00000000, 1, 0, 0, 0, 0, 32'd3, 32'hAC220004};
    vecs[14] = '{0, 1, 0, 0, 0, 0, 32'hFC000000, 1, 0, 0, 0, 0, 32'd3, 32'hAC220004};
    vecs[15] = '{0, 0, 0, 1, 0, 1, 32'h00000000, 0, 0, 0, 0, 0, 32'd3, 32'hFC000000};
    vecs[16] = '{0, 1, 1, 0, 0, 0, 32'h00000000, 0, 0, 0, 0, 1, 32'd3, 32'hFC000000};

    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("post-reset instruction", ruif.instruction, 32'd0);
    check("post-reset timeout_err", ruif.timeout_err, 1'b0);
    expect_outs("post-reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Table: ALU, LW with 3-cycle dhit delay, store-wins, halt
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].ihit, vecs[i].dhit, vecs[i].dren, vecs[i].dwen, vecs[i].halt, vecs[i].imem);
      expect_outs($sformatf("vec%0d", i), vecs[i].e_imem, vecs[i].e_dren, vecs[i].e_dwen,
                  vecs[i].e_pc, vecs[i].e_halted, vecs[i].e_ret);
      check($sformatf("vec%0d instruction", i), ruif.instruction, vecs[i].e_instr);
      tick();
    end

    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      expect_outs($sformatf("halted pulse%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
      check($sformatf("halted pulse%0d instruction", i), ruif.instruction, 32'hFC000000);
      tick();
    end

    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_outs("halt exit reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("halt exit instruction", ruif.instruction, 32'd0);

    // Random instruction stream against a transaction-level expectation
    model_retired = 32'd0;
    for (int n = 0; n < 40; n++) begin
      word = $urandom;
      fw   = $urandom_range(0, 3);
      dw   = $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      for (int c = 0; c <= fw; c++) begin
        drive(1'b0, (c == fw), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              (c == fw) ? word : $urandom);
        expect_outs($sformatf("rnd%0d fetch%0d", n, c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, model_retired);
        tick();
      end
      drive(1'b0, 1'($urandom), 1'($urandom), (kind == 1 || kind == 3), (kind >= 2), 1'b0, $urandom);
      expect_outs($sformatf("rnd%0d exec", n), 1'b0, 1'b0, 1'b0, (kind == 0), 1'b0, model_retired);
      check($sformatf("rnd%0d instruction", n), ruif.instruction, word);
      tick();
      if (kind == 0) begin
        model_retired = model_retired + 32'd1;
      end else begin
        for (int c = 0; c <= dw; c++) begin
          drive(1'b0, 1'($urandom), (c == dw), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
          expect_outs($sformatf("rnd%0d data%0d", n, c), 1'b0, (kind == 1), (kind >= 2),
                      (c == dw), 1'b0, model_retired);
          tick();
        end
        model_retired = model_retired + 32'd1;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("rnd final retired", ruif.retired, model_retired);

    // Reset while a store is pending; the late dhit must be ignored
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_outs("rstdata pending", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_outs("rstdata in reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_outs("rstdata late dhit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("rstdata instruction", ruif.instruction, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_outs("rstdata after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    do_reset();
`ifdef REQ_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      expect_outs($sformatf("wdog wait%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      check($sformatf("wdog wait%0d timeout_err", c), ruif.timeout_err, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_outs("wdog tripped", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    check("wdog timeout_err", ruif.timeout_err, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("wdog sticky", ruif.timeout_err, 1'b1);
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("wdog cleared by reset", ruif.timeout_err, 1'b0);
`else
    for (int c = 0; c < 1000; c++) begin
      drive(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_outs("nowdog 1000", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("nowdog timeout_err", ruif.timeout_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
